quadrilatero_grant_lock: RTL and testbench

QUADRILATERO_GRANT_LOCK -- requirements
Module: quadrilatero_grant_lock

---
 rtl/quadrilatero_pkg.sv | 13 +
 rtl/quadrilatero_grant_lock.sv | 151 +++++++++++++++
 tb/tb_quadrilatero_grant_lock.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quadrilatero_pkg.sv
// Shared state encoding and default parameter values for the quadrilatero grant-lock path.
package quadrilatero_pkg;

    localparam int unsigned DEFAULT_PORTS     = 4;
    localparam int unsigned DEFAULT_DATA_W    = 32;
    localparam int unsigned DEFAULT_MAX_BEATS = 16;

    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_e;

endpackage

// File: rtl/quadrilatero_grant_lock.sv
// Burst-granular grant lock in front of an external fixed-priority arbiter, with a one-entry output register.
// Optional burst length limit enabled by defining QUADRILATERO_BURST_LIMIT_EN.
module quadrilatero_grant_lock
    import quadrilatero_pkg::*;
#(
    parameter int unsigned PORTS     = DEFAULT_PORTS,
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned MAX_BEATS = DEFAULT_MAX_BEATS
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PORTS-1:0]           req_valid_i,
    input  logic [PORTS-1:0]           req_last_i,
    input  logic [PORTS*DATA_W-1:0]    req_data_i,
    output logic [PORTS-1:0]           req_ready_o,
    output logic [PORTS-1:0]           arb_req_o,
    input  logic [PORTS-1:0]           arb_grant_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic                       out_last_o,
    output logic [$clog2(PORTS)-1:0]   out_port_o,
    output logic                       burst_err_o
);

    localparam int unsigned IDX_W = $clog2(PORTS);

    if (PORTS < 2 || MAX_BEATS < 1) begin : g_param_check
        $error("quadrilatero_grant_lock: PORTS must be >= 2 and MAX_BEATS >= 1");
    end

    lock_state_e        state_q, state_d;
    logic [PORTS-1:0]   lock_q, lock_d;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic               out_last_q;
    logic [IDX_W-1:0]   out_port_q;

    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic [IDX_W-1:0]   sel_idx;
    logic               slot_free;
    logic               accept;
    logic               limit_hit;
    logic               end_burst;

    // Lock is one-hot, so the OR-style mux simply picks the locked port.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        sel_idx  = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (lock_q[i]) begin
                sel_data = req_data_i[i*DATA_W +: DATA_W];
                sel_last = req_last_i[i];
                sel_idx  = IDX_W'(i);
            end
        end
    end

    assign slot_free   = !out_valid_q || out_ready_i;
    assign accept      = (state_q == LOCKED) && |(req_valid_i & lock_q) && slot_free;
    assign end_burst   = sel_last || limit_hit;
    assign req_ready_o = (state_q == LOCKED) ? (lock_q & {PORTS{slot_free}}) : '0;
    assign arb_req_o   = (state_q == IDLE) ? req_valid_i : '0;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        unique case (state_q)
            IDLE: begin
                if (|arb_grant_i) begin
                    lock_d  = arb_grant_i;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && end_burst) begin
                    lock_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                lock_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            lock_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_port_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_last_q  <= end_burst;
                out_port_q  <= sel_idx;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef QUADRILATERO_BURST_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             burst_err_q;

    // The MAX_BEATS-th beat without a real last terminates the burst itself.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        limit_hit  = 1'b0;
        if (state_q == IDLE) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            limit_hit  = !sel_last && (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_q  <= '0;
            burst_err_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            burst_err_q <= limit_hit;
        end
    end

    assign burst_err_o = burst_err_q;
`else
    assign limit_hit   = 1'b0;
    assign burst_err_o = 1'b0;
`endif

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_port_o  = out_port_q;

endmodule

// File: tb/tb_quadrilatero_grant_lock.sv
// Directed scoreboard bench for quadrilatero_grant_lock; the external fixed-priority arbiter is modelled here.
module tb_quadrilatero_grant_lock;

    localparam int unsigned PORTS  = 4;
    localparam int unsigned DATA_W = 32;
`ifdef QUADRILATERO_BURST_LIMIT_EN
    localparam int unsigned MAXB     = 4;
    localparam int unsigned TP_BEATS = 4;
`else
    localparam int unsigned MAXB     = 16;
    localparam int unsigned TP_BEATS = 8;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int unsigned       gap;
    } beat_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [1:0]        port;
        logic              err;
    } exp_t;

    logic                     clk;
    logic                     rst;
    logic [PORTS-1:0]         tb_valid;
    logic [PORTS-1:0]         tb_last;
    logic [PORTS*DATA_W-1:0]  tb_data;
    logic [PORTS-1:0]         req_ready;
    logic [PORTS-1:0]         arb_req;
    logic [PORTS-1:0]         arb_grant;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic [1:0]               out_port;
    logic                     burst_err;

    beat_t pq [PORTS][$];
    exp_t  exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_hs     = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    int err_pulses = 0;

    quadrilatero_grant_lock #(
        .PORTS    (PORTS),
        .DATA_W   (DATA_W),
        .MAX_BEATS(MAXB)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(tb_valid),
        .req_last_i (tb_last),
        .req_data_i (tb_data),
        .req_ready_o(req_ready),
        .arb_req_o  (arb_req),
        .arb_grant_i(arb_grant),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .out_port_o (out_port),
        .burst_err_o(burst_err)
    );

    // External fixed-priority arbiter: lowest requesting index wins.
    assign arb_grant = arb_req & (~arb_req + 1'b1);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int p, input logic [DATA_W-1:0] d, input logic l, input int unsigned gap);
        beat_t b;
        b.data = d; b.last = l; b.gap = gap;
        pq[p].push_back(b);
    endtask

    task automatic expect_beat(input logic [1:0] p, input logic [DATA_W-1:0] d, input logic l, input logic e);
        exp_t x;
        x.data = d; x.last = l; x.port = p; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic drain(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #2;
        check(tag, exp_q.size(), 0);
    endtask

    // Port driver: a beat stays presented until a handshake is seen, then the next one follows.
    initial begin : driver
        logic [PORTS-1:0] hs;
        int unsigned gapc [PORTS];
        tb_valid = '0;
        tb_last  = '0;
        tb_data  = '0;
        hs       = '0;
        for (int p = 0; p < PORTS; p++) gapc[p] = 0;
        forever begin
            @(negedge clk);
            hs = tb_valid & req_ready;
            @(posedge clk); #1;
            for (int p = 0; p < PORTS; p++) begin
                if (rst) begin
                    pq[p].delete();
                    tb_valid[p] = 1'b0;
                    gapc[p] = 0;
                end else begin
                    if (hs[p]) begin
                        void'(pq[p].pop_front());
                        tb_valid[p] = 1'b0;
                    end
                    if (!tb_valid[p] && pq[p].size() != 0) begin
                        if (gapc[p] < pq[p][0].gap) begin
                            gapc[p]++;
                        end else begin
                            tb_valid[p] = 1'b1;
                            tb_data[p*DATA_W +: DATA_W] = pq[p][0].data;
                            tb_last[p] = pq[p][0].last;
                            gapc[p] = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && burst_err) err_pulses++;
            if (!rst && out_valid && out_ready) begin
                n_hs++;
                if (n_hs == 1) first_cyc = cyc;
                last_cyc = cyc;
                check("beat_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                    check("out_port", out_port, e.port);
                    check("out_burst_err", burst_err, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned n;
        out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_port", out_port, 0);
        check("rst_burst_err", burst_err, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_arb_req", arb_req, 0);
        rst = 1'b0;

        // Two contenders: port 1 wins, 3-beat burst, bubble, then port 3.
        @(posedge clk); #2;
        send(1, 32'hA, 1'b0, 0); send(1, 32'hB, 1'b0, 0); send(1, 32'hC, 1'b1, 0);
        send(3, 32'hD1, 1'b0, 0); send(3, 32'hD2, 1'b1, 0);
        expect_beat(1, 32'hA, 0, 0); expect_beat(1, 32'hB, 0, 0); expect_beat(1, 32'hC, 1, 0);
        expect_beat(3, 32'hD1, 0, 0); expect_beat(3, 32'hD2, 1, 0);
        @(posedge clk); #2;
        check("idle_arb_req", arb_req, 4'b1010);
        check("idle_req_ready", req_ready, 4'b0000);
        @(posedge clk); #2;
        check("locked_req_ready", req_ready, 4'b0010);
        check("locked_arb_req", arb_req, 4'b0000);
        @(posedge clk); #2;
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data", out_data, 32'hA);
        check("lat_out_port", out_port, 1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("bubble_arb_req", arb_req, 4'b1000);
        check("bubble_req_ready", req_ready, 4'b0000);
        @(posedge clk); #2;
        check("port3_req_ready", req_ready, 4'b1000);
        drain("drain_two_bursts", 50);

        // Backpressure: register full, downstream stalled for 5 cycles.
        out_ready = 1'b0;
        send(1, 32'h11, 1'b0, 0); send(1, 32'h22, 1'b0, 0); send(1, 32'h33, 1'b1, 0);
        expect_beat(1, 32'h11, 0, 0); expect_beat(1, 32'h22, 0, 0); expect_beat(1, 32'h33, 1, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("stall_fill", out_valid, 1);
        repeat (5) begin
            @(posedge clk); #2;
            check("stall_ready1", req_ready[1], 0);
            check("stall_data", out_data, 32'h11);
            check("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        drain("drain_stall", 50);

        // Locked port 2 idles mid-burst while port 0 waits.
        send(2, 32'h200, 1'b0, 0); send(2, 32'h201, 1'b0, 0);
        send(2, 32'h202, 1'b0, 3); send(2, 32'h203, 1'b1, 0);
        send(0, 32'h100, 1'b1, 2);
        expect_beat(2, 32'h200, 0, 0); expect_beat(2, 32'h201, 0, 0);
        expect_beat(2, 32'h202, 0, 0); expect_beat(2, 32'h203, 1, 0);
        expect_beat(0, 32'h100, 1, 0);
        repeat (5) @(posedge clk);
        #2;
        check("gap_req_ready", req_ready, 4'b0100);
        check("gap_arb_req", arb_req, 4'b0000);
        drain("drain_gap", 60);

        // Full-throughput burst.
        n_hs = 0;
        for (int i = 0; i < int'(TP_BEATS); i++) begin
            send(0, 32'h300 + i, (i == int'(TP_BEATS) - 1), 0);
            expect_beat(0, 32'h300 + i, (i == int'(TP_BEATS) - 1), 0);
        end
        drain("drain_tp", 60);
        check("tp_count", n_hs, TP_BEATS);
        check("tp_span", last_cyc - first_cyc, TP_BEATS - 1);

        // Reset mid-burst, then a fresh arbitration.
        for (int i = 0; i < 4; i++) begin
            send(3, 32'h400 + i, (i == 3), 0);
            expect_beat(3, 32'h400 + i, (i == 3), 0);
        end
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 0);
        check("mrst_out_last", out_last, 0);
        check("mrst_out_port", out_port, 0);
        check("mrst_burst_err", burst_err, 0);
        check("mrst_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        send(2, 32'h500, 1'b1, 0);
        send(1, 32'h510, 1'b1, 0);
        expect_beat(1, 32'h510, 1, 0);
        expect_beat(2, 32'h500, 1, 0);
        drain("drain_rearb", 50);

`ifdef QUADRILATERO_BURST_LIMIT_EN
        // Over-long burst: 4th beat forced last with an error pulse; remainder is a new burst.
        err_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            send(1, 32'h600 + i, 1'b0, 0);
            expect_beat(1, 32'h600 + i, (i == 3), (i == 3));
        end
        drain("drain_limit", 60);
        check("limit_err_pulses", err_pulses, 1);
`else
        check("no_err_pulses", err_pulses, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
